// File: rtl/sensor_level_quantizer.sv
// sensor_level_quantizer: turns raw ADC samples from four environmental
// sensors into debounced 2-bit levels. Each accepted sample takes three
// clocks (IDLE -> CLASSIFY -> UPDATE). CLASSIFY counts the thresholds the
// sample clears, with hysteresis around the committed level. UPDATE runs
// the persistence filter for the addressed channel only.
// Optional feature: define SQ_STALE_DETECT_EN to add per-channel stale
// timeout counters; without it level_stale is tied to zero.
module sensor_level_quantizer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned T1           = 64,
  parameter int unsigned T2           = 128,
  parameter int unsigned T3           = 192,
  parameter int unsigned HYST         = 4,
  parameter int unsigned PERSIST      = 3,
  parameter int unsigned STALE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [1:0]        sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  output logic [1:0]        level_temperature,
  output logic [1:0]        level_humidity,
  output logic [1:0]        level_light,
  output logic [1:0]        level_soil,
  output logic [3:0]        level_seen,
  output logic [3:0]        level_change,
  output logic [3:0]        level_stale
);

  localparam int unsigned CMP_W = DATA_W + 1;
  localparam int unsigned CNT_W = $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] PERSIST_CNT = CNT_W'(PERSIST);

  typedef enum logic [1:0] {IDLE, CLASSIFY, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          cand_q, cand_d;
  logic [1:0]          hits;

  logic [1:0]          level_q [4];
  logic [1:0]          level_d [4];
  logic [1:0]          pend_q  [4];
  logic [1:0]          pend_d  [4];
  logic [CNT_W-1:0]    cnt_q   [4];
  logic [CNT_W-1:0]    cnt_d   [4];
  logic [CNT_W-1:0]    cnt_next;
  logic [3:0]          seen_q, seen_d;
  logic [3:0]          change_q, change_d;

  // Threshold idx (0..2 for T1..T3) in DATA_W+1 bits: lowered by HYST
  // (floored at 0) once the committed level is at or above it, otherwise
  // raised by HYST (capped at 2^DATA_W, which no sample can reach).
  function automatic logic [CMP_W-1:0] threshold(input int idx, input logic at_or_below);
    longint unsigned t;
    longint unsigned lim;
    longint unsigned full;
    case (idx)
      0:       t = 64'(T1);
      1:       t = 64'(T2);
      default: t = 64'(T3);
    endcase
    full = 64'(1) << DATA_W;
    if (at_or_below) begin
      lim = (t > 64'(HYST)) ? t - 64'(HYST) : 64'(0);
    end else begin
      lim = t + 64'(HYST);
      if (lim > full) lim = full;
    end
    return CMP_W'(lim);
  endfunction

  // Handshake FSM: accept in IDLE, then one cycle each to classify and update.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ch_d         = ch_q;
    data_d       = data_q;
    sample_ready = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          ch_d    = sample_ch;
          data_d  = sample_data;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: state_d = UPDATE;
      UPDATE:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Candidate level: number of thresholds cleared, hysteresis keyed to the
  // committed level of the captured channel.
  always_comb begin
    cand_d = cand_q;
    hits   = '0;
    if (state_q == CLASSIFY) begin
      for (int i = 0; i < 3; i++) begin
        if ({1'b0, data_q} >= threshold(i, i < int'(level_q[ch_q]))) hits = hits + 2'd1;
      end
      cand_d = hits;
    end
  end

  // Persistence filter for the addressed channel; all others hold.
  always_comb begin
    level_d  = level_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    change_d = '0;
    cnt_next = '0;
    if (state_q == UPDATE) begin
      if (!seen_q[ch_q]) begin
        level_d[ch_q] = cand_q;
        seen_d[ch_q]  = 1'b1;
        cnt_d[ch_q]   = '0;
      end else if (cand_q == level_q[ch_q]) begin
        cnt_d[ch_q] = '0;
      end else begin
        if (cnt_q[ch_q] == '0 || cand_q != pend_q[ch_q]) begin
          pend_d[ch_q] = cand_q;
          cnt_next     = CNT_W'(1);
        end else begin
          cnt_next = cnt_q[ch_q] + CNT_W'(1);
        end
        if (cnt_next == PERSIST_CNT) begin
          level_d[ch_q]  = cand_q;
          cnt_d[ch_q]    = '0;
          change_d[ch_q] = 1'b1;
        end else begin
          cnt_d[ch_q] = cnt_next;
        end
      end
    end
  end

  // FSM state and captured sample registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      data_q  <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      cand_q  <= cand_d;
    end
  end

  // Per-channel committed level, pending candidate, counter, seen and pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these small per-channel arrays are reset element by element
      // because their reset values are architecturally visible.
      for (int i = 0; i < 4; i++) begin
        level_q[i] <= 2'd2;
        pend_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      seen_q   <= '0;
      change_q <= '0;
    end else begin
      level_q  <= level_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      change_q <= change_d;
    end
  end

  assign level_temperature = level_q[0];
  assign level_humidity    = level_q[1];
  assign level_light       = level_q[2];
  assign level_soil        = level_q[3];
  assign level_seen        = seen_q;
  assign level_change      = change_q;

`ifdef SQ_STALE_DETECT_EN
  localparam int unsigned STALE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

  logic [STALE_W-1:0] stale_cnt_q [4];

  // Saturating idle counters, cleared when a sample for the channel updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stale_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (state_q == UPDATE && ch_q == 2'(i)) stale_cnt_q[i] <= '0;
        else if (stale_cnt_q[i] != STALE_MAX) stale_cnt_q[i] <= stale_cnt_q[i] + STALE_W'(1);
      end
    end
  end

  // Stale flag follows its counter, so it drops together with the clear.
  always_comb begin
    level_stale = '0;
    for (int i = 0; i < 4; i++) level_stale[i] = (stale_cnt_q[i] == STALE_MAX);
  end
`else
  assign level_stale = '0;
`endif

endmodule

// File: tb/tb_sensor_level_quantizer.sv
// Self-checking bench for sensor_level_quantizer: a behavioural model
// pushes the expected outputs at each accept; they are popped and compared
// two clocks later when the DUT commits.
module tb_sensor_level_quantizer;

  localparam int DATA_W       = 8;
  localparam int T1           = 64;
  localparam int T2           = 128;
  localparam int T3           = 192;
  localparam int HYST         = 4;
  localparam int PERSIST      = 3;
  localparam int STALE_CYCLES = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic              sample_ready;
  logic [1:0]        sample_ch;
  logic [DATA_W-1:0] sample_data;
  logic [1:0]        level_temperature, level_humidity, level_light, level_soil;
  logic [3:0]        level_seen, level_change, level_stale;

  sensor_level_quantizer #(
    .DATA_W(DATA_W), .T1(T1), .T2(T2), .T3(T3), .HYST(HYST),
    .PERSIST(PERSIST), .STALE_CYCLES(STALE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_ch(sample_ch), .sample_data(sample_data),
    .level_temperature(level_temperature), .level_humidity(level_humidity),
    .level_light(level_light), .level_soil(level_soil),
    .level_seen(level_seen), .level_change(level_change), .level_stale(level_stale)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] lvl;   // {soil, light, humidity, temperature}
    logic [3:0] seen;
    logic [3:0] chg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_level[4];
  int m_pend[4];
  int m_cnt[4];
  bit m_seen[4];

  function automatic int model_cand(input int data, input int lvl);
    int c = 0;
    for (int i = 1; i <= 3; i++) begin
      int t   = (i == 1) ? T1 : (i == 2) ? T2 : T3;
      int lim = (i <= lvl) ? ((t - HYST < 0) ? 0 : t - HYST) : t + HYST;
      if (data >= lim) c++;
    end
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_level[i] = 2; m_pend[i] = 0; m_cnt[i] = 0; m_seen[i] = 0;
    end
    sb_q.delete();
  endtask

  task automatic model_accept(input int ch, input int data);
    exp_t e;
    int   c = model_cand(data, m_level[ch]);
    bit   chg = 0;
    if (!m_seen[ch]) begin
      m_level[ch] = c; m_seen[ch] = 1; m_cnt[ch] = 0;
    end else if (c == m_level[ch]) begin
      m_cnt[ch] = 0;
    end else begin
      if (m_cnt[ch] == 0 || c != m_pend[ch]) begin
        m_pend[ch] = c; m_cnt[ch] = 1;
      end else begin
        m_cnt[ch] = m_cnt[ch] + 1;
      end
      if (m_cnt[ch] == PERSIST) begin
        m_level[ch] = c; m_cnt[ch] = 0; chg = 1;
      end
    end
    e.lvl  = {2'(m_level[3]), 2'(m_level[2]), 2'(m_level[1]), 2'(m_level[0])};
    e.seen = {m_seen[3], m_seen[2], m_seen[1], m_seen[0]};
    e.chg  = '0;
    e.chg[ch] = chg;
    sb_q.push_back(e);
  endtask

  // Pops the oldest expectation and compares every level-related output.
  task automatic sb_compare(input string tag);
    exp_t e;
    logic [7:0] lv;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty at commit", tag);
      return;
    end
    e  = sb_q.pop_front();
    lv = {level_soil, level_light, level_humidity, level_temperature};
    if (lv !== e.lvl) begin
      errors++;
      $display("FAIL %s levels got %h expected %h", tag, lv, e.lvl);
    end
    checks++;
    if (level_seen !== e.seen) begin
      errors++;
      $display("FAIL %s level_seen got %b expected %b", tag, level_seen, e.seen);
    end
    checks++;
    if (level_change !== e.chg) begin
      errors++;
      $display("FAIL %s level_change got %b expected %b", tag, level_change, e.chg);
    end
  endtask

  // One full transaction; entered and left at #1 after a rising edge.
  task automatic drive_sample(input int ch, input int data, input string tag);
    int waited = 0;
    while (sample_ready !== 1'b1 && waited < 8) begin
      @(posedge clk); #1; waited++;
    end
    if (sample_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s ready timeout got %b expected 1", tag, sample_ready);
      return;
    end
    sample_valid = 1'b1;
    sample_ch    = 2'(ch);
    sample_data  = DATA_W'(data);
    @(posedge clk);
    model_accept(ch, data);
    #1;
    sample_valid = 1'b0;
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++; $display("FAIL %s ready@N got %b expected 0", tag, sample_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++; $display("FAIL %s ready@N+1 got %b expected 0", tag, sample_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready@N+2 got %b expected 1", tag, sample_ready);
    end
    sb_compare(tag);
    checks++;
`ifdef SQ_STALE_DETECT_EN
    if (level_stale[ch] !== 1'b0) begin
      errors++; $display("FAIL %s stale got %b expected 0", tag, level_stale[ch]);
    end
`else
    if (level_stale !== 4'b0) begin
      errors++; $display("FAIL %s stale got %b expected 0000", tag, level_stale);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (level_change !== 4'b0) begin
      errors++; $display("FAIL %s change pulse too long got %b expected 0000", tag, level_change);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b0; sample_ch = '0; sample_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({level_soil, level_light, level_humidity, level_temperature} !== 8'hAA) begin
      errors++;
      $display("FAIL reset levels got %h expected aa",
               {level_soil, level_light, level_humidity, level_temperature});
    end
    checks++;
    if (level_seen !== 4'b0 || level_change !== 4'b0) begin
      errors++; $display("FAIL reset seen/change got %b/%b expected 0000/0000", level_seen, level_change);
    end
    checks++;
    if (sample_ready !== 1'b1 || level_stale !== 4'b0) begin
      errors++; $display("FAIL reset ready/stale got %b/%b expected 1/0000", sample_ready, level_stale);
    end
  endtask

  task automatic test_first_sample();
    drive_sample(0, 30, "first_ch0");
  endtask

  task automatic test_hysteresis();
    drive_sample(1, 100, "hyst_init");
    for (int k = 0; k < 5; k++) drive_sample(1, 130, "hyst_below_up");
    for (int k = 0; k < 3; k++) drive_sample(1, 132, "hyst_at_up");
    for (int k = 0; k < 5; k++) drive_sample(1, 125, "hyst_above_down");
    drive_sample(1, 123, "hyst_below_down");
  endtask

  task automatic test_persistence();
    int seq[6] = '{200, 200, 10, 200, 200, 200};
    drive_sample(2, 10, "persist_init");
    foreach (seq[k]) drive_sample(2, seq[k], "persist_seq");
  endtask

  // Valid held high; accepts must land every third edge and bytes offered
  // while ready is low (aimed at channel 0) must be ignored.
  task automatic test_back_to_back();
    int seq[7] = '{250, 20, 20, 20, 100, 100, 100};
    sample_valid = 1'b1;
    sample_ch    = 2'd3;
    sample_data  = DATA_W'(seq[0]);
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL b2b ready at start got %b expected 1", sample_ready);
    end
    foreach (seq[k]) begin
      @(posedge clk);
      model_accept(3, seq[k]);
      #1;
      sample_ch = 2'd0; sample_data = 8'd250;
      checks++;
      if (sample_ready !== 1'b0) begin
        errors++; $display("FAIL b2b ready@N got %b expected 0", sample_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (sample_ready !== 1'b0) begin
        errors++; $display("FAIL b2b ready@N+1 got %b expected 0", sample_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (sample_ready !== 1'b1) begin
        errors++; $display("FAIL b2b ready@N+2 got %b expected 1", sample_ready);
      end
      sb_compare("b2b");
      if (k + 1 < 7) begin
        sample_ch = 2'd3; sample_data = DATA_W'(seq[k + 1]);
      end else begin
        sample_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    sample_valid = 1'b1; sample_ch = 2'd0; sample_data = 8'd250;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (sample_ready !== 1'b1 || level_temperature !== 2'd2 || level_seen !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset during got ready=%b temp=%0d seen=%b expected 1/2/0000",
               sample_ready, level_temperature, level_seen);
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset ready got %b expected 1", sample_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({level_soil, level_light, level_humidity, level_temperature} !== 8'hAA ||
        level_seen !== 4'b0 || level_change !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset after got levels=%h seen=%b chg=%b expected aa/0000/0000",
               {level_soil, level_light, level_humidity, level_temperature}, level_seen, level_change);
    end
  endtask

  task automatic test_stale();
`ifdef SQ_STALE_DETECT_EN
    drive_sample(0, 30, "stale_arm");  // returns one edge after the clear
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (level_stale[0] !== 1'b0) begin
      errors++; $display("FAIL stale early got %b expected 0", level_stale[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (level_stale[0] !== 1'b1 || level_temperature !== 2'd0) begin
      errors++;
      $display("FAIL stale timeout got stale=%b temp=%0d expected 1/0", level_stale[0], level_temperature);
    end
    drive_sample(0, 30, "stale_clear");
`endif
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_hysteresis();
    test_persistence();
    test_back_to_back();
    test_reset_mid();
    test_stale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
